// File: rtl/input64_pkg.sv
// input64_pkg
//   Shared definitions for the 72-bit codeword path (input64 and output64).
//   Holds the codeword FSM state encoding and the codeword geometry.
package input64_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10
  } cw_state_t;

  localparam int CW_BYTES = 9;
  localparam int CW_WIDTH = 72;

endpackage

// File: rtl/input64_uart_rx.sv
// uart_rx
//   8N1 serial receiver. The line is synchronised, each bit is sampled near
//   its centre, and a completed frame produces a one-cycle strobe.
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous, active-low reset
//   uart_rxd  serial line, idle high
//   rx_data   last received byte, valid with rx_valid
//   rx_valid  one-cycle strobe per good frame
//   rx_break  one-cycle strobe when a stop bit is sampled low (break/framing)
module uart_rx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_break
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       data_nx;
  logic             valid_nx, break_nx;
  logic             rxd_meta, rxd_sync;

  // Two-flop synchroniser; resets to the idle (high) level so no false start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      shift    <= shift_nx;
      rx_data  <= data_nx;
      rx_valid <= valid_nx;
      rx_break <= break_nx;
    end
  end

  // The start bit is re-checked half a bit after the falling edge, which
  // rejects glitches and aligns every later sample to a bit centre.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    data_nx    = rx_data;
    valid_nx   = 1'b0;
    break_nx   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          state_nx = RX_START;
          cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (!rxd_sync) begin
            state_nx   = RX_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = RX_IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {rxd_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nx = RX_STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rxd_sync) begin
            valid_nx = 1'b1;
            data_nx  = shift;
            state_nx = RX_IDLE;
          end else begin
            break_nx = 1'b1;
            state_nx = RX_WAIT_HIGH;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line must return high before a new start is believed.
        if (rxd_sync) begin
          state_nx = RX_IDLE;
        end
      end
      default: begin
        state_nx = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/input64.sv
// input64
//   Receives serial bytes and assembles nine of them into a 72-bit codeword
//   (64 data + 8 check bits), first byte in the least significant position.
//   The finished codeword is held with cw_valid until the consumer takes it.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   uart_rxd     serial receive line, idle high
//   codeWord     assembled codeword, stable while cw_valid
//   cw_valid     codeWord complete and not yet accepted
//   cw_ready     consumer accepts codeWord when high with cw_valid
//   timeout_err  pulse: partial codeword abandoned after inter-byte timeout
//   frame_err    pulse: receiver saw a break/framing error
//   overrun_err  pulse: byte dropped because a codeword was still held
module input64
  import input64_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int BIT_RATE       = 9600,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rxd,
  output logic [CW_WIDTH-1:0] codeWord,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic                timeout_err,
  output logic                frame_err,
  output logic                overrun_err
);

  localparam logic [3:0]       LAST_BYTE = 4'(CW_BYTES - 1);
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_break;

  cw_state_t  state, state_nx;
  logic [3:0] byte_cnt, byte_cnt_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
  logic [CW_WIDTH-9:0] shadow;
  logic       store_byte;
  logic [2:0] store_slot;
  logic       load_word;
  logic       timeout_nx, frame_nx, overrun_nx;

  uart_rx #(
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE)
  ) u_uart_rx (
    .clk     (clk),
    .resetn  (!reset),
    .uart_rxd(uart_rxd),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_break(rx_break)
  );

  assign cw_valid = (state == HOLD);

  // Bytes 0..7 collect in the shadow register; the ninth byte is merged
  // straight into codeWord so the visible word only changes on entry to HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      shadow      <= '0;
      codeWord    <= '0;
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nx;
      byte_cnt    <= byte_cnt_nx;
      tmo_cnt     <= tmo_cnt_nx;
      timeout_err <= timeout_nx;
      frame_err   <= frame_nx;
      overrun_err <= overrun_nx;
      if (store_byte) begin
        shadow[{store_slot, 3'b000} +: 8] <= rx_data;
      end
      if (load_word) begin
        codeWord <= {rx_data, shadow};
      end
    end
  end

  // A break always raises frame_err; within COLLECT it outranks both a byte
  // and the timeout. In HOLD an accept in the same cycle as a new byte lets
  // that byte start the next codeword instead of counting as an overrun.
  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    tmo_cnt_nx  = '0;
    store_byte  = 1'b0;
    store_slot  = 3'd0;
    load_word   = 1'b0;
    timeout_nx  = 1'b0;
    frame_nx    = rx_break;
    overrun_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          store_byte  = 1'b1;
          byte_cnt_nx = 4'd1;
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_break) begin
          state_nx    = IDLE;
          byte_cnt_nx = '0;
        end else if (rx_valid) begin
          if (byte_cnt == LAST_BYTE) begin
            load_word   = 1'b1;
            byte_cnt_nx = '0;
            state_nx    = HOLD;
          end else begin
            store_byte  = 1'b1;
            store_slot  = byte_cnt[2:0];
            byte_cnt_nx = byte_cnt + 4'd1;
          end
        end else if (tmo_cnt >= TMO_LAST) begin
          timeout_nx  = 1'b1;
          byte_cnt_nx = '0;
          state_nx    = IDLE;
        end else begin
          tmo_cnt_nx = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        end
      end
      HOLD: begin
        if (cw_ready) begin
          if (rx_valid) begin
            store_byte  = 1'b1;
            byte_cnt_nx = 4'd1;
            state_nx    = COLLECT;
          end else begin
            state_nx = IDLE;
          end
        end else if (rx_valid) begin
          overrun_nx = 1'b1;
        end
      end
      default: begin
        state_nx    = IDLE;
        byte_cnt_nx = '0;
      end
    endcase
  end

endmodule

// File: doc/input64.md
INPUT64 -- requirements
Module: input64

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency passed to the UART receiver.
REQ-002 Parameter BIT_RATE, default 9600, serial bit rate passed to the UART receiver.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, maximum clk cycles allowed between consecutive bytes of one codeword.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 uart_rxd  input  1  serial receive line, idle high.
REQ-007 codeWord  output  72  assembled codeword: 64 data bits plus 8 check bits.
REQ-008 cw_valid  output  1  codeWord holds a complete, unconsumed codeword.
REQ-009 cw_ready  input  1  consumer accepts codeWord when high with cw_valid.
REQ-010 timeout_err  output  1  one-cycle pulse when a partial codeword is abandoned on inter-byte timeout.
REQ-011 frame_err  output  1  one-cycle pulse when the UART receiver flags a break/framing error.
REQ-012 overrun_err  output  1  one-cycle pulse when a byte arrives while a completed codeword is still unaccepted.

Function
REQ-013 The block SHALL receive 9 bytes per codeword; the first byte received SHALL land in codeWord[7:0] and byte k in codeWord[8k+7:8k].
REQ-014 The FSM SHALL have states IDLE, COLLECT, HOLD; reset state IDLE.
REQ-015 IDLE: on a received byte, store it as byte 0, set byteCnt to 1, go to COLLECT.
REQ-016 COLLECT: each received byte SHALL be stored at index byteCnt and byteCnt incremented; on storing byte 8, go to HOLD.
REQ-017 cw_valid SHALL assert in the cycle after byte 8 is stored and SHALL be high exactly while in HOLD.
REQ-018 codeWord SHALL be stable while cw_valid is high; bytes are written into a shadow register, copied to codeWord on entry to HOLD.
REQ-019 HOLD: when cw_valid and cw_ready are both high on a clock edge, return to IDLE with cw_valid low next cycle.
REQ-020 A byte received in HOLD SHALL be discarded and SHALL pulse overrun_err; codeWord unchanged.
REQ-021 A byte received in the same cycle as the HOLD acceptance SHALL be taken as byte 0 of the next codeword (state to COLLECT, byteCnt 1), not an overrun.
REQ-022 In COLLECT, a counter SHALL reset on each received byte; reaching TIMEOUT_CYCLES with no byte SHALL pulse timeout_err, clear byteCnt, return to IDLE.
REQ-023 A framing/break error in any state SHALL pulse frame_err; in COLLECT it SHALL also discard the partial codeword and return to IDLE; in HOLD codeWord is retained.
REQ-024 byteCnt SHALL be 4 bits and never exceed 8; the timeout counter SHALL saturate and not wrap.
REQ-025 Error pulses SHALL be exactly one clk cycle and may coincide with each other.

Reset
REQ-026 Reset SHALL force state IDLE, byteCnt 0, timeout counter 0, codeWord 72'h0, cw_valid 0, all error pulses 0, regardless of mid-codeword progress.
REQ-027 After reset release, the first byte received SHALL be treated as byte 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, COLLECT=2'b01, HOLD=2'b10), CW_BYTES=9 and CW_WIDTH=72, also used by output64.
REQ-029 One sub-module SHALL be instantiated: uart_rx (resetn = !reset), supplying an 8-bit byte, a one-cycle byte-valid strobe, and a break flag.
REQ-030 No other sub-modules; byte assembly, timeout and FSM SHALL reside in input64.

Verification
REQ-031 Serial bytes 0x01..0x09 with cw_ready high -> cw_valid one cycle, codeWord=72'h090807060504030201.
REQ-032 Send 4 bytes then idle beyond TIMEOUT_CYCLES -> one timeout_err pulse, cw_valid never high; then 9 bytes 0xAA -> codeWord all 0xAA.
REQ-033 cw_ready low, send 9 bytes then byte 0x55 -> cw_valid held, overrun_err pulses once, codeWord unchanged; raise cw_ready -> cw_valid drops next cycle.
REQ-034 Assert reset after byte 5 of a codeword -> all outputs zero; next 9 bytes 0x10..0x18 -> codeWord=72'h181716151413121110.
REQ-035 Inject break condition after byte 3 -> frame_err one pulse, return to IDLE, following full codeword received correctly.
REQ-036 Back-to-back codewords with cw_ready high -> two cw_valid pulses, each with correct data, no error pulses.
